// File: rtl/mem_pkg.sv
// Shared constants and requester encoding for the RAM arbiter.
package mem_pkg;

    localparam int             ADDR_W     = 15;
    localparam int             DATA_W     = 8;
    localparam logic [14:0]    VIDEO_BASE = 15'h2800;
    localparam int             STARVE_MAX = 8;
    localparam logic [7:0]     OOR_RDATA  = 8'hFF;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_VID  = 2'd2,
        REQ_DMA  = 2'd3
    } req_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker; the pointer toggles after every grant it issues.
module rr_pick2 (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr;  // 0: side a has priority

    assign gnt_a = en & req_a & (~ptr | ~req_b);
    assign gnt_b = en & req_b & ( ptr | ~req_a);

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= 1'b0;
        else if (gnt_a | gnt_b)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: VGA priority with starvation bound, CPU/DMA round-robin,
// one-cycle tagged read-return pipeline.
module mem_arbiter #(
    parameter int                  ADDR_W     = mem_pkg::ADDR_W,
    parameter int                  DATA_W     = mem_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]   VIDEO_BASE = mem_pkg::VIDEO_BASE,
    parameter int                  STARVE_MAX = mem_pkg::STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W:0]   vid_addr,
    output logic              vid_ready,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W:0]   dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    import mem_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] last_addr;
    req_e              tag, rd_grant;
    logic              tag_oor, oor;
    logic              others, vid_gnt, cpu_gnt, dma_gnt;
    logic [DATA_W-1:0] rdata;

    assign others  = cpu_req | dma_req;
    assign vid_gnt = ~reset & vid_req & ((starve_cnt < CNT_W'(STARVE_MAX)) | ~others);

    rr_pick2 u_rr (
        .clock (clock),
        .reset (reset),
        .en    (~reset & ~vid_gnt),
        .req_a (cpu_req),
        .req_b (dma_req),
        .gnt_a (cpu_gnt),
        .gnt_b (dma_gnt)
    );

    assign cpu_ready = cpu_gnt;
    assign vid_ready = vid_gnt;
    assign dma_ready = dma_gnt;

    always_comb begin
        mem_address = last_addr;
        mem_data    = '0;
        mem_wren    = 1'b0;
        oor         = 1'b0;
        rd_grant    = REQ_NONE;
        if (vid_gnt) begin
            mem_address = vid_addr[ADDR_W-1:0] + VIDEO_BASE;  // wraps mod 2^ADDR_W
            rd_grant    = REQ_VID;
        end else if (cpu_gnt) begin
            mem_address = cpu_addr[ADDR_W-1:0];
            oor         = cpu_addr[ADDR_W];
            mem_data    = cpu_wdata;
            mem_wren    = cpu_we & ~cpu_addr[ADDR_W];
            rd_grant    = cpu_we ? REQ_NONE : REQ_CPU;
        end else if (dma_gnt) begin
            mem_address = dma_addr[ADDR_W-1:0];
            oor         = dma_addr[ADDR_W];
            mem_data    = dma_wdata;
            mem_wren    = dma_we & ~dma_addr[ADDR_W];
            rd_grant    = dma_we ? REQ_NONE : REQ_DMA;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag        <= REQ_NONE;
            tag_oor    <= 1'b0;
            starve_cnt <= '0;
            last_addr  <= '0;
        end else begin
            tag       <= rd_grant;
            tag_oor   <= oor;
            last_addr <= mem_address;
            if (cpu_gnt | dma_gnt | ~others)
                starve_cnt <= '0;
            else if (vid_gnt && starve_cnt < CNT_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Out-of-range reads never touched the RAM, so substitute the fixed pattern.
    assign rdata      = tag_oor ? DATA_W'(OOR_RDATA) : mem_q;
    assign cpu_rdata  = rdata;
    assign vid_rdata  = rdata;
    assign dma_rdata  = rdata;
    assign cpu_rvalid = ~reset & (tag == REQ_CPU);
    assign vid_rvalid = ~reset & (tag == REQ_VID);
    assign dma_rvalid = ~reset & (tag == REQ_DMA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;

    logic        clock = 0, reset = 1;
    logic        cpu_req = 0, cpu_we = 0, vid_req = 0, dma_req = 0, dma_we = 0;
    logic [15:0] cpu_addr = 0, vid_addr = 0, dma_addr = 0;
    logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
    logic        cpu_ready, cpu_rvalid, vid_ready, vid_rvalid, dma_ready, dma_rvalid, mem_wren;
    logic [7:0]  cpu_rdata, vid_rdata, dma_rdata, mem_data, mem_q;
    logic [14:0] mem_address;

    int tests = 0, fails = 0;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ready(vid_ready), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Registered-output RAM macro
    logic [7:0] ram [0:32767];
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    logic [7:0] ref_mem [0:32767];

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic idle;
        cpu_req = 0; vid_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
    endtask

    task automatic do_reset;
        idle(); reset = 1; tick(); reset = 0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d; tick();
        cpu_req = 0; cpu_we = 0;
    endtask

    task automatic test_reset;
        reset = 1; cpu_req = 1; cpu_we = 1; vid_req = 1; dma_req = 1; tick(); tick(); #4;
        tests++; if ({cpu_ready, vid_ready, dma_ready} !== 3'b000) begin
            fails++; $display("FAIL reset_ready: got %b want 000", {cpu_ready, vid_ready, dma_ready}); end
        tests++; if ({cpu_rvalid, vid_rvalid, dma_rvalid} !== 3'b000) begin
            fails++; $display("FAIL reset_rvalid: got %b want 000", {cpu_rvalid, vid_rvalid, dma_rvalid}); end
        tests++; if (mem_wren !== 1'b0) begin
            fails++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
        idle(); reset = 0; tick();
    endtask

    task automatic test_cpu_read;
        idle(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0123; cpu_wdata = 8'hA5; #4;
        tests++; if ({cpu_ready, mem_wren, mem_address, mem_data} !== {1'b1, 1'b1, 15'h0123, 8'hA5}) begin
            fails++; $display("FAIL cpu_write: got rdy=%b wren=%b addr=%h data=%h want 1 1 0123 a5",
                              cpu_ready, mem_wren, mem_address, mem_data); end
        tick(); cpu_we = 0; #4;
        tests++; if ({cpu_ready, mem_wren, mem_address} !== {1'b1, 1'b0, 15'h0123}) begin
            fails++; $display("FAIL cpu_read_issue: got rdy=%b wren=%b addr=%h want 1 0 0123",
                              cpu_ready, mem_wren, mem_address); end
        tick(); cpu_req = 0; #4;
        tests++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hA5}) begin
            fails++; $display("FAIL cpu_read_data: got v=%b d=%h want 1 a5", cpu_rvalid, cpu_rdata); end
        tick();
    endtask

    task automatic test_vid_wrap;
        cpu_write(16'h2800, 8'h3C);
        cpu_write(16'h0000, 8'h5A);
        vid_req = 1; vid_addr = 16'h0000; #4;
        tests++; if ({vid_ready, mem_wren, mem_address} !== {1'b1, 1'b0, 15'h2800}) begin
            fails++; $display("FAIL vid_base: got rdy=%b wren=%b addr=%h want 1 0 2800",
                              vid_ready, mem_wren, mem_address); end
        tick(); vid_addr = 16'h5800; #4;
        tests++; if ({vid_ready, mem_address} !== {1'b1, 15'h0000}) begin
            fails++; $display("FAIL vid_wrap: got rdy=%b addr=%h want 1 0000", vid_ready, mem_address); end
        tests++; if ({vid_rvalid, vid_rdata} !== {1'b1, 8'h3C}) begin
            fails++; $display("FAIL vid_data0: got v=%b d=%h want 1 3c", vid_rvalid, vid_rdata); end
        tick(); vid_req = 0; #4;
        tests++; if ({vid_rvalid, vid_rdata} !== {1'b1, 8'h5A}) begin
            fails++; $display("FAIL vid_data1: got v=%b d=%h want 1 5a", vid_rvalid, vid_rdata); end
        tick();
    endtask

    task automatic test_starve;
        do_reset();
        vid_req = 1; vid_addr = 16'h0000; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0000;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 9; i++) begin
                #4;
                tests++; if ({vid_ready, cpu_ready} !== {i < 8, i == 8}) begin
                    fails++; $display("FAIL starve r%0d c%0d: got vid=%b cpu=%b want %b %b",
                                      r, i, vid_ready, cpu_ready, i < 8, i == 8); end
                tick();
            end
        idle(); tick();
    endtask

    task automatic test_round_robin;
        do_reset();
        cpu_req = 1; dma_req = 1; cpu_addr = 16'h0000; dma_addr = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            #4;
            tests++; if ({cpu_ready, dma_ready} !== {i % 2 == 0, i % 2 == 1}) begin
                fails++; $display("FAIL rr c%0d: got cpu=%b dma=%b want %b %b",
                                  i, cpu_ready, dma_ready, i % 2 == 0, i % 2 == 1); end
            tick();
        end
        idle(); tick();
    endtask

    task automatic test_oor;
        cpu_write(16'h0010, 8'h11);
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h8010; cpu_wdata = 8'h77; #4;
        tests++; if ({cpu_ready, mem_wren} !== 2'b10) begin
            fails++; $display("FAIL oor_write: got rdy=%b wren=%b want 1 0", cpu_ready, mem_wren); end
        tick(); cpu_we = 0; tick(); cpu_addr = 16'h0010; #4;
        tests++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hFF}) begin
            fails++; $display("FAIL oor_read: got v=%b d=%h want 1 ff", cpu_rvalid, cpu_rdata); end
        tick(); cpu_req = 0; #4;
        tests++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h11}) begin
            fails++; $display("FAIL oor_ram_kept: got v=%b d=%h want 1 11", cpu_rvalid, cpu_rdata); end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        dma_req = 1; dma_we = 0; dma_addr = 16'h0000; #4;
        tests++; if (dma_ready !== 1'b1) begin
            fails++; $display("FAIL rst_mid_grant: got %b want 1", dma_ready); end
        tick(); dma_req = 0; reset = 1; #4;
        tests++; if (dma_rvalid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_during: got rvalid=%b want 0", dma_rvalid); end
        tick(); reset = 0; cpu_req = 1; dma_req = 1; cpu_addr = 16'h0000; #4;
        tests++; if ({dma_rvalid, cpu_ready, dma_ready} !== 3'b010) begin
            fails++; $display("FAIL rst_mid_after: got rv=%b cpu=%b dma=%b want 0 1 0",
                              dma_rvalid, cpu_ready, dma_ready); end
        tick(); idle(); tick();
    endtask

    task automatic test_random;
        logic        cp = 0, cw = 0, dp = 0, dw = 0, vp = 0;
        logic [15:0] ca = 0, da = 0, va = 0;
        logic [7:0]  cd = 0, dd = 0, act, exp_rd = 0, nxt_rd;
        logic [2:0]  exp_rv = 0, nxt_rv;
        logic        eg_c, eg_v, eg_d, g_we, g_oor;
        logic [14:0] g_addr;
        logic [7:0]  g_d;
        int          m_ptr, m_starve;

        do_reset();
        for (int k = 0; k < 64; k++) begin
            ref_mem[k] = 8'($urandom);
            dma_req = 1; dma_we = 1; dma_addr = 16'(k); dma_wdata = ref_mem[k]; tick();
        end
        do_reset();
        m_ptr = 0; m_starve = 0;

        for (int n = 0; n < 400; n++) begin
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1; cw = 1'($urandom_range(0, 1)); cd = 8'($urandom);
                ca = 16'($urandom_range(0, 63)); if ($urandom_range(0, 7) == 0) ca[15] = 1'b1;
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1; dw = 1'($urandom_range(0, 1)); dd = 8'($urandom);
                da = 16'($urandom_range(0, 63)); if ($urandom_range(0, 7) == 0) da[15] = 1'b1;
            end
            if (!vp && $urandom_range(0, 3) != 0) begin
                vp = 1; va = 16'h5800 + 16'($urandom_range(0, 63));
            end
            cpu_req = cp; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
            dma_req = dp; dma_we = dw; dma_addr = da; dma_wdata = dd;
            vid_req = vp; vid_addr = va;
            #4;
            eg_v = vp && (m_starve < 8 || !(cp || dp));
            eg_c = !eg_v && cp && (m_ptr == 0 || !dp);
            eg_d = !eg_v && !eg_c && dp;
            tests++; if ({cpu_ready, vid_ready, dma_ready} !== {eg_c, eg_v, eg_d}) begin
                fails++; $display("FAIL rand_grant n%0d: got %b want %b", n,
                                  {cpu_ready, vid_ready, dma_ready}, {eg_c, eg_v, eg_d}); end
            tests++; if ({cpu_rvalid, vid_rvalid, dma_rvalid} !== exp_rv) begin
                fails++; $display("FAIL rand_rvalid n%0d: got %b want %b", n,
                                  {cpu_rvalid, vid_rvalid, dma_rvalid}, exp_rv); end
            if (exp_rv != 3'b000) begin
                act = (exp_rv == 3'b100) ? cpu_rdata : (exp_rv == 3'b010) ? vid_rdata : dma_rdata;
                tests++; if (act !== exp_rd) begin
                    fails++; $display("FAIL rand_rdata n%0d: got %h want %h", n, act, exp_rd); end
            end
            g_we = 0; g_oor = 0; g_addr = 0; g_d = 0; nxt_rv = 3'b000; nxt_rd = 0;
            if (eg_v) begin
                g_addr = 15'((int'(va[14:0]) + 'h2800) % 32768); nxt_rv = 3'b010;
            end else if (eg_c) begin
                g_addr = ca[14:0]; g_oor = ca[15]; g_we = cw; g_d = cd; nxt_rv = cw ? 3'b000 : 3'b100;
            end else if (eg_d) begin
                g_addr = da[14:0]; g_oor = da[15]; g_we = dw; g_d = dd; nxt_rv = dw ? 3'b000 : 3'b001;
            end
            if (eg_v || eg_c || eg_d) begin
                tests++; if ({mem_address, mem_wren} !== {g_addr, g_we && !g_oor}) begin
                    fails++; $display("FAIL rand_mem n%0d: got addr=%h wren=%b want %h %b", n,
                                      mem_address, mem_wren, g_addr, g_we && !g_oor); end
                if (g_we && !g_oor) begin
                    tests++; if (mem_data !== g_d) begin
                        fails++; $display("FAIL rand_wdata n%0d: got %h want %h", n, mem_data, g_d); end
                end
                if (!g_we) nxt_rd = g_oor ? 8'hFF : ref_mem[g_addr];
                if (g_we && !g_oor) ref_mem[g_addr] = g_d;
            end else begin
                tests++; if (mem_wren !== 1'b0) begin
                    fails++; $display("FAIL rand_idle_wren n%0d: got %b want 0", n, mem_wren); end
            end
            if (eg_c || eg_d) begin
                m_ptr = 1 - m_ptr; m_starve = 0;
            end else if (!(cp || dp)) begin
                m_starve = 0;
            end else if (eg_v) begin
                m_starve = (m_starve < 8) ? m_starve + 1 : 8;
            end
            if (eg_c) cp = 0;
            if (eg_d) dp = 0;
            if (eg_v) vp = 0;
            exp_rv = nxt_rv; exp_rd = nxt_rd;
            tick();
        end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_vid_wrap();
        test_starve();
        test_round_robin();
        test_oor();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port 32 KB synchronous RAM between three requesters:
- VGA fetch (real-time)
- CPU core
- DMA/loader port (UART boot loader)

Issues at most one RAM access per clock. VGA has priority, bounded by an anti-starvation counter. CPU and DMA alternate round-robin. Read data is routed back with a 1-cycle tagged pipeline. Sits between core/vga/loader and the memory macro in the board top level.

Parameters:
- ADDR_W, 15, RAM address width (32 KB)
- DATA_W, 8, data width
- VIDEO_BASE, 15'h2800, offset added to VGA addresses
- STARVE_MAX, 8, max consecutive VGA grants while CPU/DMA is pending

Ports:
- clock  in  1  system clock (25 MHz domain)
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write enable
- cpu_addr  in  16  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ready  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  8  CPU read data
- vid_req  in  1  VGA fetch request (read only)
- vid_addr  in  16  VGA address, relative to VIDEO_BASE
- vid_ready  out  1  VGA request accepted this cycle
- vid_rvalid  out  1  VGA read data valid
- vid_rdata  out  8  VGA read data
- dma_req, dma_we, dma_addr[16], dma_wdata[8]  in  DMA request, same meaning as the CPU signals
- dma_ready, dma_rvalid, dma_rdata[8]  out  DMA responses, same meaning as the CPU signals
- mem_address  out  15  RAM address
- mem_data  out  8  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  8  RAM read data, registered in RAM (valid 1 cycle after address)

Behaviour:
- Reset (synchronous, active-high):
  - tag = NONE, rr_ptr = CPU, starve_cnt = 0.
  - All rvalid = 0. mem_wren = 0.
  - ready outputs are combinational, so they are 0 while reset is high.
  - Reads in flight are discarded; rvalid is 0 on the cycle after reset.
- Grant selection (combinational, same cycle):
  1. vid_req is granted if (starve_cnt < STARVE_MAX) or neither cpu_req nor dma_req is set.
  2. Otherwise the round-robin winner of cpu_req/dma_req: rr_ptr side first, the other side if rr_ptr's side is idle.
  3. No request: mem_wren = 0; mem_address holds its last value (don't-care).
  - Exactly one of cpu_ready/vid_ready/dma_ready is high when its requester wins; requesters hold req/addr/data until ready is seen.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on a VGA grant while cpu_req or dma_req is high.
  - Clears on any CPU/DMA grant, or on any cycle with no CPU/DMA request pending.
- rr_ptr: flips to the other side after each CPU or DMA grant. Unchanged on VGA grants or idle cycles.
- Address mapping:
  - VGA: mem_address = vid_addr[14:0] + VIDEO_BASE, modulo 2^15 (wraps; 16'h5800 -> 15'h0000).
  - CPU/DMA: mem_address = addr[14:0].
  - If addr[15] = 1 (out of range): the access is accepted with ready = 1, mem_wren is forced to 0, and a read returns 8'hFF.
- Writes: mem_wren = granted we and not out-of-range. mem_data = granted wdata. No read response.
- Read pipeline:
  - On a read grant, tag <= {requester, oor}.
  - Next cycle: the tagged requester's rvalid = 1, rdata = (oor ? 8'hFF : mem_q). All other rvalid = 0.
  - Back-to-back reads give one result per cycle. Latency is exactly 1 cycle after ready.
- rdata outputs of non-valid ports are don't-care.
- Simultaneous req from all three: VGA wins, subject to the starve rule.

Decomposition:
- Shared package mem_pkg:
  - requester enum (REQ_NONE, REQ_CPU, REQ_VID, REQ_DMA)
  - ADDR_W, DATA_W, VIDEO_BASE constants
  - OOR read value 8'hFF
- One natural sub-module, rr_pick2: two-requester round-robin with a pointer register.
- Top level instantiates mem_arbiter in place of the direct core/vga memory wiring.

Test Plan:
1. CPU read alone: cpu_req = 1, cpu_addr = 16'h0123, RAM[0x123] = 8'hA5 -> cpu_ready the same cycle, cpu_rvalid = 1 with cpu_rdata = 8'hA5 next cycle.
2. VGA offset wrap: vid_addr = 16'h0000 -> mem_address = 15'h2800; vid_addr = 16'h5800 -> 15'h0000. vid_rvalid is 1 cycle later with the correct data.
3. Starvation: vid_req and cpu_req held high -> 8 VGA grants, then 1 CPU grant (cpu_ready pulse), pattern repeats, starve_cnt returns to 0 after each CPU grant.
4. Round-robin: cpu_req and dma_req held, vid_req = 0 -> grants alternate CPU, DMA, CPU, DMA starting from CPU after reset.
5. Out of range: cpu_we = 1, cpu_addr = 16'h8010 -> cpu_ready = 1, mem_wren = 0, RAM unchanged. A read of 16'h8010 returns 8'hFF.
6. Reset mid-read: grant a DMA read, assert reset the next cycle -> dma_rvalid = 0, tag cleared; after reset deasserts, the first CPU/DMA grant goes to CPU.
